// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one prefetch request per cycle and
// registers {pc, instr, comp, exc} toward decode with stall, redirect and fence handling.
module fetch_stage #(
    parameter logic [31:0] START_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        pf_valid,
    output logic        pf_fence,
    output logic [31:0] pf_addr,
    input  logic [31:0] pf_rdata,
    input  logic        pf_ready,
    input  logic        redir_valid,
    input  logic [31:0] redir_addr,
    input  logic        redir_fence,
    input  logic        dec_stall,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_comp,
    output logic        out_exc
);

    typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_p0;
    logic        fence_pend;
    logic        fetch;
    logic        take;

    logic        vld_p1;
    logic [31:0] pc_p1;
    logic [31:0] instr_p1;
    logic        comp_p1;
    logic        exc_p1;

    function automatic logic is_rvc(input logic [31:0] w);
        return w[1:0] != 2'b11;
    endfunction

    function automatic logic [31:0] align_instr(input logic [31:0] w);
        return is_rvc(w) ? {16'h0000, w[15:0]} : w;
    endfunction

    function automatic logic [31:0] pc_step(input logic [31:0] pc, input logic comp);
        return pc + (comp ? 32'd2 : 32'd4);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state_q <= BOOT;
        else     state_q <= state_d;
    end

    // Request stage (p0): redirect outranks stall, which outranks fetch
    always_comb begin
        state_d  = state_q;
        fetch    = 1'b0;
        pf_valid = 1'b0;
        pf_fence = 1'b0;
        pf_addr  = '0;
        if (redir_valid)           state_d = redir_addr[0] ? HALT : RUN;
        else if (state_q == BOOT)  state_d = RUN;
        fetch    = !rst && !redir_valid && !dec_stall && (state_q == RUN);
        pf_valid = fetch;
        pf_fence = fetch && fence_pend;
        pf_addr  = fetch ? pc_p0 : '0;
    end

    assign take = fetch && pf_ready;

    // Output register stage (p1): holds under stall so nothing is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_p0      <= START_ADDR;
            fence_pend <= 1'b0;
            vld_p1     <= 1'b0;
            pc_p1      <= '0;
            instr_p1   <= '0;
            comp_p1    <= 1'b0;
            exc_p1     <= 1'b0;
        end else if (redir_valid) begin
            fence_pend <= redir_fence;
            if (redir_addr[0]) begin
                vld_p1   <= 1'b1;
                exc_p1   <= 1'b1;
                pc_p1    <= redir_addr;
                instr_p1 <= '0;
                comp_p1  <= 1'b0;
            end else begin
                pc_p0  <= redir_addr;
                vld_p1 <= 1'b0;
                exc_p1 <= 1'b0;
            end
        end else if (dec_stall) begin
            vld_p1 <= vld_p1;
        end else if (take) begin
            pc_p0      <= pc_step(pc_p0, is_rvc(pf_rdata));
            fence_pend <= 1'b0;
            vld_p1     <= 1'b1;
            exc_p1     <= 1'b0;
            pc_p1      <= pc_p0;
            instr_p1   <= align_instr(pf_rdata);
            comp_p1    <= is_rvc(pf_rdata);
        end else begin
            vld_p1 <= 1'b0;
            exc_p1 <= 1'b0;
        end
    end

    assign out_valid = vld_p1;
    assign out_pc    = pc_p1;
    assign out_instr = instr_p1;
    assign out_comp  = comp_p1;
    assign out_exc   = exc_p1;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table for the named corner cases, then a
// randomized run checked against a rule-level reference model.
module tb_fetch_stage;

    localparam logic [31:0] START = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pf_valid, pf_fence;
    logic [31:0] pf_addr;
    logic [31:0] pf_rdata = '0;
    logic        pf_ready = 1'b0;
    logic        redir_valid = 1'b0;
    logic [31:0] redir_addr = '0;
    logic        redir_fence = 1'b0;
    logic        dec_stall = 1'b0;
    logic        out_valid, out_comp, out_exc;
    logic [31:0] out_pc, out_instr;

    int checks = 0;
    int failures = 0;

    fetch_stage #(.START_ADDR(START)) dut (
        .clk(clk), .rst(rst),
        .pf_valid(pf_valid), .pf_fence(pf_fence), .pf_addr(pf_addr),
        .pf_rdata(pf_rdata), .pf_ready(pf_ready),
        .redir_valid(redir_valid), .redir_addr(redir_addr), .redir_fence(redir_fence),
        .dec_stall(dec_stall),
        .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
        .out_comp(out_comp), .out_exc(out_exc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, rv;
        logic [31:0] ra;
        logic        rf, st, rdy;
        logic [31:0] rd;
        logic        epv;
        logic [31:0] epa;
        logic        epf, eov;
        logic [31:0] epc, ein;
        logic        ecomp, eexc;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic rv, input logic [31:0] ra, input logic rf,
                       input logic st, input logic rdy, input logic [31:0] rd,
                       input logic epv, input logic [31:0] epa, input logic epf,
                       input logic eov, input logic [31:0] epc, input logic [31:0] ein,
                       input logic ecomp, input logic eexc);
        vec_t v;
        v.rst = r; v.rv = rv; v.ra = ra; v.rf = rf; v.st = st; v.rdy = rdy; v.rd = rd;
        v.epv = epv; v.epa = epa; v.epf = epf; v.eov = eov; v.epc = epc; v.ein = ein;
        v.ecomp = ecomp; v.eexc = eexc;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic r, input logic rv, input logic [31:0] ra, input logic rf,
                         input logic st, input logic rdy, input logic [31:0] rd);
        rst = r; redir_valid = rv; redir_addr = ra; redir_fence = rf;
        dec_stall = st; pf_ready = rdy; pf_rdata = rd;
    endtask

    // Reference model state, expressed as the architectural rules of the fetch stage
    int          m_mode;   // 0 boot, 1 running, 2 halted
    logic [31:0] m_pc;
    logic        m_fence, m_ov, m_comp, m_exc;
    logic [31:0] m_opc, m_oin;

    function automatic logic m_req(input logic r, input logic rv, input logic st);
        return !r && !rv && !st && (m_mode == 1);
    endfunction

    task automatic m_step(input logic r, input logic rv, input logic [31:0] ra, input logic rf,
                          input logic st, input logic rdy, input logic [31:0] rd);
        logic req;
        req = m_req(r, rv, st);
        if (r) begin
            m_mode = 0; m_pc = START; m_fence = 0;
            m_ov = 0; m_opc = 0; m_oin = 0; m_comp = 0; m_exc = 0;
        end else if (rv) begin
            m_fence = rf;
            if (ra % 2 == 1) begin
                m_mode = 2; m_ov = 1; m_exc = 1; m_opc = ra; m_oin = 0; m_comp = 0;
            end else begin
                m_mode = 1; m_pc = ra; m_ov = 0; m_exc = 0;
            end
        end else begin
            if (m_mode == 0) m_mode = 1;
            if (!st) begin
                if (req && rdy) begin
                    m_ov = 1; m_exc = 0; m_opc = m_pc; m_fence = 0;
                    if ((rd & 32'h3) == 32'h3) begin
                        m_comp = 0; m_oin = rd; m_pc = m_pc + 4;
                    end else begin
                        m_comp = 1; m_oin = rd & 32'h0000_FFFF; m_pc = m_pc + 2;
                    end
                end else begin
                    m_ov = 0; m_exc = 0;
                end
            end
        end
    endtask

    initial begin
        logic        r, rv, rf, st, rdy, req;
        logic [31:0] ra, rd;

        // Directed vectors: inputs applied for one cycle, pf_* checked before the edge,
        // out_* checked after it.
        //   rst rv ra            rf st rdy rd             epv epa           epf eov epc           ein           cmp exc
        add(1, 0, 0,            0, 0, 0, 0,            0, 0,            0, 0, 0,            0,            0, 0);
        add(0, 0, 0,            0, 0, 0, 0,            0, 0,            0, 0, 0,            0,            0, 0);
        add(0, 0, 0,            0, 0, 1, 32'h13,       1, 32'h80,       0, 1, 32'h80,       32'h13,       0, 0);
        add(0, 0, 0,            0, 0, 1, 32'h13,       1, 32'h84,       0, 1, 32'h84,       32'h13,       0, 0);
        add(0, 0, 0,            0, 0, 1, 32'hDEAD4501, 1, 32'h88,       0, 1, 32'h88,       32'h4501,     1, 0);
        add(0, 0, 0,            0, 0, 1, 32'h00A00093, 1, 32'h8A,       0, 1, 32'h8A,       32'h00A00093, 0, 0);
        add(0, 0, 0,            0, 0, 0, 32'h13,       1, 32'h8E,       0, 0, 0,            0,            0, 0);
        add(0, 0, 0,            0, 0, 0, 32'h13,       1, 32'h8E,       0, 0, 0,            0,            0, 0);
        add(0, 0, 0,            0, 0, 0, 32'h13,       1, 32'h8E,       0, 0, 0,            0,            0, 0);
        add(0, 0, 0,            0, 0, 1, 32'h13,       1, 32'h8E,       0, 1, 32'h8E,       32'h13,       0, 0);
        add(0, 0, 0,            0, 1, 1, 32'h33,       0, 0,            0, 1, 32'h8E,       32'h13,       0, 0);
        add(0, 0, 0,            0, 1, 1, 32'h33,       0, 0,            0, 1, 32'h8E,       32'h13,       0, 0);
        add(0, 0, 0,            0, 1, 1, 32'h33,       0, 0,            0, 1, 32'h8E,       32'h13,       0, 0);
        add(0, 1, 32'h400,      0, 1, 1, 32'h33,       0, 0,            0, 0, 0,            0,            0, 0);
        add(0, 0, 0,            0, 0, 1, 32'h13,       1, 32'h400,      0, 1, 32'h400,      32'h13,       0, 0);
        add(0, 1, 32'h80,       1, 0, 1, 32'h13,       0, 0,            0, 0, 0,            0,            0, 0);
        add(0, 0, 0,            0, 0, 0, 32'h13,       1, 32'h80,       1, 0, 0,            0,            0, 0);
        add(0, 0, 0,            0, 0, 1, 32'h13,       1, 32'h80,       1, 1, 32'h80,       32'h13,       0, 0);
        add(0, 0, 0,            0, 0, 1, 32'h13,       1, 32'h84,       0, 1, 32'h84,       32'h13,       0, 0);
        add(0, 1, 32'h301,      0, 0, 1, 32'h13,       0, 0,            0, 1, 32'h301,      0,            0, 1);
        add(0, 0, 0,            0, 0, 1, 32'h13,       0, 0,            0, 0, 0,            0,            0, 0);
        add(0, 0, 0,            0, 0, 1, 32'h13,       0, 0,            0, 0, 0,            0,            0, 0);
        add(0, 1, 32'h300,      0, 0, 1, 32'h13,       0, 0,            0, 0, 0,            0,            0, 0);
        add(0, 0, 0,            0, 0, 1, 32'h13,       1, 32'h300,      0, 1, 32'h300,      32'h13,       0, 0);
        add(0, 1, 32'hFFFFFFFE, 0, 0, 1, 32'h13,       0, 0,            0, 0, 0,            0,            0, 0);
        add(0, 0, 0,            0, 0, 1, 32'h12340001, 1, 32'hFFFFFFFE, 0, 1, 32'hFFFFFFFE, 32'h0001,     1, 0);
        add(0, 0, 0,            0, 0, 1, 32'h13,       1, 32'h0,        0, 1, 32'h0,        32'h13,       0, 0);
        add(0, 1, 32'h40,       1, 0, 1, 32'h13,       0, 0,            0, 0, 0,            0,            0, 0);
        add(1, 0, 0,            0, 0, 1, 32'h13,       0, 0,            0, 0, 0,            0,            0, 0);
        add(0, 0, 0,            0, 0, 1, 32'h13,       0, 0,            0, 0, 0,            0,            0, 0);
        add(0, 0, 0,            0, 0, 1, 32'h13,       1, 32'h80,       0, 1, 32'h80,       32'h13,       0, 0);

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].rv, tbl[i].ra, tbl[i].rf, tbl[i].st, tbl[i].rdy, tbl[i].rd);
            #3;
            chk($sformatf("vec%0d.pf_valid", i), {31'b0, pf_valid}, {31'b0, tbl[i].epv});
            chk($sformatf("vec%0d.pf_addr", i), pf_addr, tbl[i].epa);
            chk($sformatf("vec%0d.pf_fence", i), {31'b0, pf_fence}, {31'b0, tbl[i].epf});
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d.out_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].eov});
            if (tbl[i].eov || tbl[i].rst) begin
                chk($sformatf("vec%0d.out_pc", i), out_pc, tbl[i].epc);
                chk($sformatf("vec%0d.out_instr", i), out_instr, tbl[i].ein);
                chk($sformatf("vec%0d.out_comp", i), {31'b0, out_comp}, {31'b0, tbl[i].ecomp});
                chk($sformatf("vec%0d.out_exc", i), {31'b0, out_exc}, {31'b0, tbl[i].eexc});
            end
        end

        // Randomized run against the reference model
        m_mode = 0; m_pc = START; m_fence = 0;
        m_ov = 0; m_opc = 0; m_oin = 0; m_comp = 0; m_exc = 0;
        for (int c = 0; c < 3000; c++) begin
            r   = (c == 0) || ($urandom_range(0, 199) == 0);
            rv  = ($urandom_range(0, 19) == 0);
            ra  = {$urandom_range(0, 255), 4'h0} + 32'($urandom_range(0, 3) * 2);
            if ($urandom_range(0, 5) == 0) ra = ra | 32'h1;
            if ($urandom_range(0, 15) == 0) ra = 32'hFFFF_FFFC + 32'($urandom_range(0, 1) * 2);
            rf  = ($urandom_range(0, 2) == 0);
            st  = ($urandom_range(0, 3) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            rd  = $urandom;
            drive(r, rv, ra, rf, st, rdy, rd);
            #3;
            req = m_req(r, rv, st);
            chk("rnd.pf_valid", {31'b0, pf_valid}, {31'b0, req});
            chk("rnd.pf_addr", pf_addr, req ? m_pc : 32'h0);
            chk("rnd.pf_fence", {31'b0, pf_fence}, {31'b0, req && m_fence});
            m_step(r, rv, ra, rf, st, rdy, rd);
            @(posedge clk);
            #1;
            chk("rnd.out_valid", {31'b0, out_valid}, {31'b0, m_ov});
            if (m_ov) begin
                chk("rnd.out_pc", out_pc, m_opc);
                chk("rnd.out_instr", out_instr, m_oin);
                chk("rnd.out_comp", {31'b0, out_comp}, {31'b0, m_comp});
                chk("rnd.out_exc", {31'b0, out_exc}, {31'b0, m_exc});
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
